uart_tx_framed: RTL and testbench
=================================

// Module: uart_tx_framed
// PURPOSE
//  Multi-word UART transmitter with configurable parity and stop bits. Takes a
//  NUM_WORDS x BITS_PER_WORD vector on a valid/ready handshake and serialises it
//  onto tx, LSB first. Frames go out back-to-back: word 0 first.
//  Each frame is start(0), data, optional parity, then 1 or 2 stop bits (1).
//  Sits between the accelerator output stage and the board UART pin.
// PARAMETERS
//  CLOCKS_PER_PULSE  4      clk cycles per bit; >=2 (e.g. 200_000_000/9600)
//  BITS_PER_WORD     8      data bits per frame, 5..9
//  W_OUT             24     total payload width; must be a multiple of BITS_PER_WORD
//  NUM_WORDS         W_OUT/BITS_PER_WORD (localparam) frames per transfer
//  PARITY            PAR_NONE  parity_t: PAR_NONE / PAR_EVEN / PAR_ODD
//  STOP_BITS         1      1 or 2
// PORTS
//  clk      in   1                          system clock, single domain
//  rstn     in   1                          asynchronous, active-low reset
//  s_valid  in   1                          payload valid
//  s_data   in   [NUM_WORDS][BITS_PER_WORD] payload; word 0 is sent first
//  s_ready  out  1                          block idle; can accept
//  tx       out  1                          serial line, idle high
//  busy     out  1                          transfer in progress
//  done     out  1                          1-cycle pulse after last stop bit
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE, tx=1, busy=0, done=0, counters=0.
//   s_ready=(state==IDLE) is therefore 1 in and out of reset.
//  Accept: the transfer is taken when s_valid&&s_ready at a rising edge (cycle T).
//   s_data is captured into a shift register at T. s_data is don't-care afterwards.
//  Latency: tx is registered. It goes 0 at T+1 (start bit), no glitches.
//  Bit timing: each bit holds for exactly CLOCKS_PER_PULSE cycles. c_clocks counts
//   0..CLOCKS_PER_PULSE-1 and advances the bit on terminal count.
//  Frame bits: FB = 1 + BITS_PER_WORD + (PARITY!=PAR_NONE) + STOP_BITS.
//  Transfer length: NUM_WORDS*FB*CLOCKS_PER_PULSE cycles. There is no gap between frames.
//  Parity: EVEN gives ^word. ODD gives ~^word. It is computed from the captured word,
//   not from live s_data.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> (START of next word | IDLE)
//   IDLE   tx=1. On accept go to START with c_words=0.
//   START  tx=0 for 1 bit.
//   DATA   tx=data[c_bits], c_bits 0..BITS_PER_WORD-1.
//   PARITY tx=parity bit; skipped when PAR_NONE.
//   STOP   tx=1 for STOP_BITS bits. At the end:
//          - if c_words==NUM_WORDS-1, go to IDLE and pulse done;
//          - otherwise increment c_words and go to START.
//  busy = (state!=IDLE). After done, s_ready=1 the same cycle. The earliest next
//   start bit is 1 cycle after that, so there are >=CLOCKS_PER_PULSE+1 cycles of
//   line-high between transfers. Only the stop bits plus that one cycle count here.
//  s_valid while busy is ignored; it is not queued. Holding s_valid through done
//   starts the next transfer immediately.
//  Reset mid-transfer: tx returns to 1 asynchronously. The partial frame is
//   abandoned and no done pulse is produced.
//  Counter widths: $clog2 of each range, with a minimum of 1 bit. All compares are
//   against terminal counts, with no wrap dependence.
//  Elaboration: $error if W_OUT%BITS_PER_WORD!=0, if STOP_BITS is not in {1,2}, or
//   if CLOCKS_PER_PULSE<2.
// STRUCTURE
//  uart_pkg: typedef enum parity_t {PAR_NONE,PAR_EVEN,PAR_ODD};
//   typedef enum tx_state_t {IDLE,START,DATA,PARITY,STOP};
//   function frame_bits(bpw,par,stop).
//  Sub-module uart_baud_tick #(CLOCKS_PER_PULSE): clk, rstn, clr -> tick. The tick
//   fires on the last cycle of each bit and clr restarts it on accept.
//   It is reused by the future RX.
//  The top holds the FSM, the word/bit counters, the payload shift register and
//   the tx register.
// TESTING (CLOCKS_PER_PULSE=4, BITS_PER_WORD=8, W_OUT=24 unless noted)
//  1 Reset idle: rstn=0->1, no valid -> tx=1, s_ready=1, busy=0, done=0 for 100 cycles.
//  2 PAR_NONE, 1 stop, s_data={8'h03,8'h81,8'hA5} -> frames A5,81,03. Each frame
//    is 0,LSB-first data,1 with 4 cycles per bit. done arrives 120 cycles after
//    accept; the line is sampled mid-bit.
//  3 PAR_EVEN, word 8'hA5 -> parity bit 0; word 8'h01 -> parity bit 1.
//    Frame is 11 bits = 44 cycles.
//  4 PAR_ODD, STOP_BITS=2, word 8'h00 -> parity 1 followed by 2 stop bits.
//    Total is 3*12*4 = 144 cycles.
//  5 Handshake: pulse s_valid mid-transfer with new data. Required: ignored and the
//    output is unchanged. Hold s_valid high: the next start bit comes 1 cycle
//    after done.
//  6 Reset at bit 5 of word 1 -> tx=1 immediately, s_ready=1, no done. A following
//    transfer is bit-exact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Bits on the wire for one frame: start + data + optional parity + stop bits.
  function automatic int frame_bits(input int bpw, input parity_t par, input int stop);
    return 1 + bpw + ((par != PAR_NONE) ? 1 : 0) + stop;
  endfunction

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick is high on the last clk cycle of every bit.
// clr holds the count at zero so the first bit after an accept is full length.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick
);

  localparam int CW = clog2_min1(CLOCKS_PER_PULSE);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLOCKS_PER_PULSE - 1);

  logic [CW-1:0] c_clocks_q, c_clocks_d;

  // Next count: restart on clear or terminal count, otherwise advance.
  always_comb begin
    // NOTE: every path assigns c_clocks_d, so no latch is inferred.
    c_clocks_d = c_clocks_q + CW'(1);
    if (clr || (c_clocks_q == CLK_LAST)) c_clocks_d = '0;
  end

  // Count register.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (!rstn) c_clocks_q <= '0;
    else       c_clocks_q <= c_clocks_d;
  end

  assign tick = (c_clocks_q == CLK_LAST);

endmodule

// File: rtl/uart_tx_framed.sv
// Multi-word UART transmitter: accepts NUM_WORDS words in one handshake and
// sends them back-to-back, word 0 first, each as start/data/[parity]/stop.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int      CLOCKS_PER_PULSE = 4,
  parameter int      BITS_PER_WORD    = 8,
  parameter int      W_OUT            = 24,
  parameter parity_t PARITY           = PAR_NONE,
  parameter int      STOP_BITS        = 1
) (
  input  logic                                             clk,
  input  logic                                             rstn,
  input  logic                                             s_valid,
  input  logic [W_OUT/BITS_PER_WORD-1:0][BITS_PER_WORD-1:0] s_data,
  output logic                                             s_ready,
  output logic                                             tx,
  output logic                                             busy,
  output logic                                             done
);

  localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int BW        = clog2_min1(BITS_PER_WORD);
  localparam int SW        = clog2_min1(STOP_BITS);
  localparam int WW        = clog2_min1(NUM_WORDS);

  localparam logic [BW-1:0] BIT_LAST  = BW'(BITS_PER_WORD - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(NUM_WORDS - 1);

  if (W_OUT % BITS_PER_WORD != 0) begin : g_bad_width
    $error("uart_tx_framed: W_OUT must be a multiple of BITS_PER_WORD");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_framed: STOP_BITS must be 1 or 2");
  end
  if (CLOCKS_PER_PULSE < 2) begin : g_bad_cpp
    $error("uart_tx_framed: CLOCKS_PER_PULSE must be at least 2");
  end

  // Parity of one captured word; EVEN makes the total count of ones even.
  function automatic logic word_parity(input logic [BITS_PER_WORD-1:0] w);
    return (PARITY == PAR_ODD) ? ~^w : ^w;
  endfunction

  // The state PARITY is shadowed by the parameter of the same name, so the
  // state is always referenced with its package scope.
  tx_state_t         state_q, state_d;
  logic [BW-1:0]     c_bits_q, c_bits_d;
  logic [SW-1:0]     c_stop_q, c_stop_d;
  logic [WW-1:0]     c_words_q, c_words_d;
  logic [W_OUT-1:0]  shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              tick;

  // Bit timer is held in reset while idle so each transfer starts on a full bit.
  uart_baud_tick #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)
  ) u_baud (
    .clk (clk),
    .rstn(rstn),
    .clr (state_q == IDLE),
    .tick(tick)
  );

  // Next state, counters, payload shifting and the registered line value.
  always_comb begin
    state_d   = state_q;
    c_bits_d  = c_bits_q;
    c_stop_d  = c_stop_q;
    c_words_d = c_words_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_valid) begin
          state_d   = START;
          c_words_d = '0;
          shift_d   = s_data;
          parity_d  = word_parity(s_data[0]);
        end
      end
      START: begin
        if (tick) begin
          state_d  = DATA;
          c_bits_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          // The word being sent always sits in the low bits of the shifter.
          shift_d = shift_q >> 1;
          if (c_bits_q == BIT_LAST) begin
            c_stop_d = '0;
            state_d  = (PARITY == PAR_NONE) ? STOP : uart_pkg::PARITY;
          end else begin
            c_bits_d = c_bits_q + BW'(1);
          end
        end
      end
      uart_pkg::PARITY: begin
        if (tick) begin
          state_d  = STOP;
          c_stop_d = '0;
        end
      end
      STOP: begin
        if (tick) begin
          if (c_stop_q == STOP_LAST) begin
            if (c_words_q == WORD_LAST) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d   = START;
              c_words_d = c_words_q + WW'(1);
              parity_d  = word_parity(shift_q[BITS_PER_WORD-1:0]);
            end
          end else begin
            c_stop_d = c_stop_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is driven from the state being entered so it changes on the same
    // edge as the FSM, without a combinational path to the pin.
    case (state_d)
      START:            tx_d = 1'b0;
      DATA:             tx_d = shift_d[0];
      uart_pkg::PARITY: tx_d = parity_d;
      default:          tx_d = 1'b1;
    endcase
  end

  // State, counters, payload and line registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      c_bits_q  <= '0;
      c_stop_q  <= '0;
      c_words_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_bits_q  <= c_bits_d;
      c_stop_q  <= c_stop_d;
      c_words_q <= c_words_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign s_ready = (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign tx      = tx_q;
  assign done    = done_q;

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: three instances (no parity/1 stop, even/1 stop,
// odd/2 stop) checked cycle by cycle against a bit-list reference model.
module tb_uart_tx_framed;
  import uart_pkg::*;

  localparam int CPP = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            s_valid [3];
  logic [2:0][7:0] s_data  [3];
  logic            s_ready [3];
  logic            tx      [3];
  logic            busy    [3];
  logic            done    [3];

  // Configuration of each instance, as seen by the model: 0 none, 1 even, 2 odd.
  int par_cfg  [3] = '{0, 1, 2};
  int stop_cfg [3] = '{1, 1, 2};

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_bits [$];

  always #5 clk = ~clk;

  uart_tx_framed #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .W_OUT(24),
                   .PARITY(PAR_NONE), .STOP_BITS(1)) u_none (
    .clk(clk), .rstn(rstn), .s_valid(s_valid[0]), .s_data(s_data[0]),
    .s_ready(s_ready[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]));

  uart_tx_framed #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .W_OUT(24),
                   .PARITY(PAR_EVEN), .STOP_BITS(1)) u_even (
    .clk(clk), .rstn(rstn), .s_valid(s_valid[1]), .s_data(s_data[1]),
    .s_ready(s_ready[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]));

  uart_tx_framed #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .W_OUT(24),
                   .PARITY(PAR_ODD), .STOP_BITS(2)) u_odd (
    .clk(clk), .rstn(rstn), .s_valid(s_valid[2]), .s_data(s_data[2]),
    .s_ready(s_ready[2]), .tx(tx[2]), .busy(busy[2]), .done(done[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Status vector {tx, s_ready, busy, done} of one instance.
  function automatic logic [3:0] status(input int k);
    return {tx[k], s_ready[k], busy[k], done[k]};
  endfunction

  // Reference model: the line as a list of bit values, one entry per bit time.
  task automatic build_bits(input int k, input logic [23:0] d);
    logic [7:0] word;
    int ones;
    exp_bits.delete();
    for (int w = 0; w < 3; w++) begin
      word = d[8*w +: 8];
      ones = $countones(word);
      exp_bits.push_back(1'b0);
      for (int b = 0; b < 8; b++) exp_bits.push_back(word[b]);
      if (par_cfg[k] == 1) exp_bits.push_back(ones % 2 == 1);
      if (par_cfg[k] == 2) exp_bits.push_back(ones % 2 == 0);
      for (int s = 0; s < stop_cfg[k]; s++) exp_bits.push_back(1'b1);
    end
  endtask

  // One transfer on instance k, entered and left #1 after a rising edge.
  // glitch: pulse s_valid with junk mid-transfer. keep: hold s_valid high
  // through done (caller starts the next transfer immediately).
  // abort_at: cycle at which reset is asserted instead of finishing (-1: never).
  task automatic xfer(input int k, input logic [23:0] d, input bit glitch,
                      input bit keep, input int abort_at);
    int len;
    int inj;
    logic [3:0] want;
    build_bits(k, d);
    len = exp_bits.size() * CPP;
    inj = glitch ? int'($urandom_range(len - 8, 4)) : -1;
    s_data[k]  = d;
    s_valid[k] = 1'b1;
    check($sformatf("ready_u%0d", k), 32'(s_ready[k]), 32'd1);
    @(posedge clk); #1;
    if (!keep) s_valid[k] = 1'b0;
    s_data[k] = 24'($urandom);
    for (int c = 0; c < len; c++) begin
      if (c == abort_at) begin
        rstn = 1'b0;
        #1;
        check($sformatf("abort_u%0d", k), 32'(status(k)), 32'b1100);
        s_valid[k] = 1'b0;
        return;
      end
      if (c == inj) begin
        s_valid[k] = 1'b1;
        s_data[k]  = 24'($urandom);
      end
      if (c == inj + 1 && !keep) s_valid[k] = 1'b0;
      want = {exp_bits[c / CPP], 3'b010};
      check($sformatf("line_u%0d_c%0d", k, c), 32'(status(k)), 32'(want));
      @(posedge clk); #1;
    end
    check($sformatf("done_u%0d", k), 32'(status(k)), 32'b1101);
    if (!keep) begin
      @(posedge clk); #1;
      check($sformatf("after_u%0d", k), 32'(status(k)), 32'b1100);
    end
  endtask

  initial begin
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid[k] = 1'b0;
      s_data[k]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("in_reset_u%0d", k), 32'(status(k)), 32'b1100);
    rstn = 1'b1;

    // Idle after reset: line high, ready, not busy, no done.
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++)
        check($sformatf("idle_u%0d", k), 32'(status(k)), 32'b1100);
    end

    // Directed frames: A5,81,03 without parity; even parity on A5 and 01;
    // odd parity with two stop bits on all-zero words.
    xfer(0, {8'h03, 8'h81, 8'hA5}, 1'b0, 1'b0, -1);
    xfer(1, {8'hFF, 8'h01, 8'hA5}, 1'b0, 1'b0, -1);
    xfer(2, 24'h000000, 1'b0, 1'b0, -1);

    // Random payloads, with junk s_valid pulses while busy on some of them.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++)
        xfer(k, 24'($urandom), 1'($urandom), 1'b0, -1);

    // s_valid held through done: the next start bit follows one cycle later.
    for (int k = 0; k < 3; k++) begin
      xfer(k, 24'($urandom), 1'b1, 1'b1, -1);
      xfer(k, 24'($urandom), 1'b0, 1'b0, -1);
    end

    // Reset during data bit 5 of word 1 (bit time 16 of a 10-bit frame).
    xfer(0, 24'($urandom), 1'b0, 1'b0, 16 * CPP + 1);
    @(posedge clk); #1;
    check("rst_hold_u0", 32'(status(0)), 32'b1100);
    rstn = 1'b1;
    for (int c = 0; c < 150; c++) begin
      @(posedge clk); #1;
      check("no_done_u0", 32'(status(0)), 32'b1100);
    end
    xfer(0, 24'($urandom), 1'b0, 1'b0, -1);
    xfer(0, {8'h03, 8'h81, 8'hA5}, 1'b0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Backstop so a broken run cannot hang.
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
